// File: rtl/div_pkg.sv
// Shared definitions for the divider requester: widths, op-bit positions, FSM encodings.
package div_pkg;
    localparam int XLEN    = 64;
    localparam int TAG_W   = 5;
    localparam int OP_W    = 3;
    localparam int OP_UNS  = 0;
    localparam int OP_REM  = 1;
    localparam int OP_WORD = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic sgn);
        return sgn ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
    endfunction
endpackage

// File: rtl/div_req_ctrl_if.sv
// EXU issue, WB result and divider request/response signals of the divide requester.
interface div_req_ctrl_if;
    import div_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OP_W-1:0]     in_op;
    logic [XLEN-1:0]     in_rs1;
    logic [XLEN-1:0]     in_rs2;
    logic [TAG_W-1:0]    in_rd;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_data;
    logic [TAG_W-1:0]    out_rd;
    logic                div_flush;
    logic                div_valid;
    logic                div_signed;
    logic [XLEN-1:0]     div_dividend;
    logic [XLEN-1:0]     div_divisor;
    logic [XLEN-1:0]     div_quotient;
    logic [XLEN-1:0]     div_remainder;
    logic                div_o_valid;
    logic                div_o_ready;

    // slave: the controller; master: EXU, WB and divider around it
    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, out_ready,
               div_quotient, div_remainder, div_o_valid,
        output in_ready, out_valid, out_data, out_rd, div_flush, div_valid,
               div_signed, div_dividend, div_divisor, div_o_ready
    );
    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, out_ready,
               div_quotient, div_remainder, div_o_valid,
        input  in_ready, out_valid, out_data, out_rd, div_flush, div_valid,
               div_signed, div_dividend, div_divisor, div_o_ready
    );
endinterface

// File: rtl/div_opnd_ext.sv
// Word/sign extension of divide operands and selection/extension of the architectural result.
module div_opnd_ext
    import div_pkg::*;
(
    input  logic [OP_W-1:0] opnd_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [OP_W-1:0] res_op,
    input  logic [XLEN-1:0] quotient,
    input  logic [XLEN-1:0] remainder,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] result
);
    logic            opnd_sgn;
    logic [XLEN-1:0] sel;

    assign opnd_sgn = ~opnd_op[OP_UNS];
    assign dividend = opnd_op[OP_WORD] ? word_ext(rs1, opnd_sgn) : rs1;
    assign divisor  = opnd_op[OP_WORD] ? word_ext(rs2, opnd_sgn) : rs2;

    // *W results are always sign-extended from bit 31, even for unsigned ops
    assign sel    = res_op[OP_REM] ? remainder : quotient;
    assign result = res_op[OP_WORD] ? word_ext(sel, 1'b1) : sel;
endmodule

// File: rtl/div_req_ctrl.sv
// Requester-side controller for the 64-bit iterative divider (EXU -> divider -> WB).
// Optional DIV_ZERO_FAST_EN: divide-by-zero resolved locally at accept without issuing.
//
// state    | meaning
// IDLE     | ready for a new op from EXU
// ISSUE    | one-cycle div_valid pulse to the divider
// WAIT     | operands held, waiting for div_o_valid
// RESP     | result presented to WB until out_ready
module div_req_ctrl
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    div_req_ctrl_if.slave         bus
);
    state_t            state, state_nx;
    logic [OP_W-1:0]   op_q;
    logic [TAG_W-1:0]  rd_q;
    logic [XLEN-1:0]   dividend_q, divisor_q, data_q;
    logic [XLEN-1:0]   dividend_ext, divisor_ext, result_ext;
    logic [XLEN-1:0]   res_q_src, res_r_src;
    logic [OP_W-1:0]   res_op;
    logic              accept, capture, fast_zero;

    assign accept = (state == ST_IDLE) && bus.in_valid && !flush;

`ifdef DIV_ZERO_FAST_EN
    // in IDLE the result path computes the div-by-zero answer from the incoming op
    assign fast_zero = (divisor_ext == '0);
    assign res_op    = (state == ST_IDLE) ? bus.in_op : op_q;
    assign res_q_src = (state == ST_IDLE) ? '1 : bus.div_quotient;
    assign res_r_src = (state == ST_IDLE) ? dividend_ext : bus.div_remainder;
`else
    assign fast_zero = 1'b0;
    assign res_op    = op_q;
    assign res_q_src = bus.div_quotient;
    assign res_r_src = bus.div_remainder;
`endif

    assign capture = ((state == ST_WAIT) && bus.div_o_valid && !flush) || (accept && fast_zero);

    div_opnd_ext u_ext (
        .opnd_op   (bus.in_op),
        .rs1       (bus.in_rs1),
        .rs2       (bus.in_rs2),
        .res_op    (res_op),
        .quotient  (res_q_src),
        .remainder (res_r_src),
        .dividend  (dividend_ext),
        .divisor   (divisor_ext),
        .result    (result_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            data_q     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q       <= bus.in_op;
                rd_q       <= bus.in_rd;
                dividend_q <= dividend_ext;
                divisor_q  <= divisor_ext;
            end
            if (capture) begin
                data_q <= result_ext;
            end
        end
    end

    always_comb begin
        state_nx        = state;
        bus.in_ready    = 1'b0;
        bus.div_valid   = 1'b0;
        bus.div_o_ready = 1'b0;
        bus.out_valid   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (accept) state_nx = fast_zero ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.div_valid = 1'b1;
                state_nx      = ST_WAIT;
            end
            ST_WAIT: begin
                bus.div_o_ready = 1'b1;
                if (bus.div_o_valid) state_nx = ST_RESP;
            end
            ST_RESP: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (flush) state_nx = ST_IDLE;
    end

    assign bus.div_flush    = flush;
    assign bus.div_signed   = ~op_q[OP_UNS];
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign bus.out_data     = data_q;
    assign bus.out_rd       = rd_q;
endmodule

// File: tb/tb_div_req_ctrl.sv
// Directed bench for div_req_ctrl with a behavioural iterative-divider model.
module tb_div_req_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   lat = 1;

    div_req_ctrl_if bus();

    div_req_ctrl dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

    always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [4:0]  rd;
        int          lat;
        int          stall;
        bit          div0;
        logic [63:0] exp;
    } vec_t;

    // divider model: accepts only on div_valid, answers after lat cycles
    logic        m_busy;
    int          m_cnt;
    logic [63:0] m_q, m_r;

    task automatic model_div(input logic [63:0] a, input logic [63:0] b, input logic s,
                             output logic [63:0] q, output logic [63:0] r);
        if (b == 64'd0) begin
            q = '1;
            r = a;
        end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
            q = a;
            r = 64'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt <= 0;
            bus.div_o_valid <= 1'b0;
            bus.div_quotient <= '0;
            bus.div_remainder <= '0;
        end else if (bus.div_flush) begin
            m_busy <= 1'b0;
            bus.div_o_valid <= 1'b0;
        end else begin
            if (bus.div_o_valid && bus.div_o_ready) bus.div_o_valid <= 1'b0;
            if (bus.div_valid) begin
                model_div(bus.div_dividend, bus.div_divisor, bus.div_signed, m_q, m_r);
                m_cnt <= lat;
                m_busy <= 1'b1;
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    m_busy <= 1'b0;
                    bus.div_o_valid <= 1'b1;
                    bus.div_quotient <= m_q;
                    bus.div_remainder <= m_r;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int          idx, pulses, dov_idx;
        bit          got, moved, unstable;
        logic [63:0] d0, s0, hd;
        logic [4:0]  hr;
        lat = v.lat;
        bus.in_op = v.op;
        bus.in_rs1 = v.rs1;
        bus.in_rs2 = v.rs2;
        bus.in_rd = v.rd;
        bus.in_valid = 1'b1;
        chk({nm, " in_ready_before"}, 64'(bus.in_ready), 64'd1);
        tick;
        bus.in_valid = 1'b0;
        bus.in_rs1 = '0;
        bus.in_rs2 = '0;
        chk({nm, " div_valid_at_n1"}, 64'(bus.div_valid), (v.div0 && FAST) ? 64'd0 : 64'd1);
        idx = 0; pulses = 0; dov_idx = -1; got = 0; moved = 0;
        d0 = bus.div_dividend;
        s0 = bus.div_divisor;
        while (idx < 200) begin
            if (bus.div_valid) pulses++;
            if (bus.div_o_valid && dov_idx < 0) dov_idx = idx;
            if (bus.div_dividend !== d0 || bus.div_divisor !== s0) moved = 1;
            if (bus.out_valid) begin
                got = 1;
                break;
            end
            tick;
            idx++;
        end
        chk({nm, " out_valid_seen"}, 64'(got), 64'd1);
        if (!got) return;
        chk({nm, " out_data"}, bus.out_data, v.exp);
        chk({nm, " out_rd"}, 64'(bus.out_rd), 64'(v.rd));
        chk({nm, " div_valid_pulses"}, 64'(pulses), (v.div0 && FAST) ? 64'd0 : 64'd1);
        chk({nm, " operands_held"}, 64'(moved), 64'd0);
        if (v.div0 && FAST) chk({nm, " fast_latency"}, 64'(idx), 64'd0);
        else chk({nm, " resp_latency"}, 64'(idx), 64'(dov_idx + 1));
        if (v.stall > 0) begin
            hd = bus.out_data;
            hr = bus.out_rd;
            unstable = 0;
            repeat (v.stall) begin
                tick;
                if (!bus.out_valid || bus.in_ready || bus.out_data !== hd || bus.out_rd !== hr)
                    unstable = 1;
            end
            chk({nm, " stall_stable"}, 64'(unstable), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        chk({nm, " out_valid_after_hs"}, 64'(bus.out_valid), 64'd0);
        chk({nm, " in_ready_after_hs"}, 64'(bus.in_ready), 64'd1);
    endtask

    vec_t vecs[9];

    initial begin
        bit ov;
        vec_t v;
        vecs[0] = '{3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 4, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[1] = '{3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 1, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2] = '{3'b001, 64'd5, 64'd0, 5'd5, 3, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd6, 2, 0, 1'b0,
                    64'hFFFF_FFFF_8000_0000};
        vecs[4] = '{3'b111, 64'h0000_0000_FFFF_FFFF, 64'd2, 5'd7, 3, 0, 1'b0, 64'd1};
        vecs[5] = '{3'b101, 64'hDEAD_BEEF_FFFF_FFFE, 64'h1234_5678_0000_0002, 5'd8, 2, 0, 1'b0,
                    64'h0000_0000_7FFF_FFFF};
        vecs[6] = '{3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 5, 0, 1'b0,
                    64'h8000_0000_0000_0000};
        vecs[7] = '{3'b110, 64'h1234_5678_8000_0005, 64'hFFFF_FFFF_0000_0000, 5'd10, 2, 0, 1'b1,
                    64'hFFFF_FFFF_8000_0005};
        vecs[8] = '{3'b001, 64'd1000, 64'd10, 5'd31, 2, 5, 1'b0, 64'd100};

        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_rd = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_data", bus.out_data, 64'd0);
        chk("reset out_rd", 64'(bus.out_rd), 64'd0);
        chk("reset div_valid", 64'(bus.div_valid), 64'd0);
        chk("reset div_o_ready", 64'(bus.div_o_ready), 64'd0);
        chk("reset div_dividend", bus.div_dividend, 64'd0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // in_valid together with flush must not be accepted
        bus.in_op = 3'b001; bus.in_rs1 = 64'd9; bus.in_rs2 = 64'd3; bus.in_rd = 5'd2;
        bus.in_valid = 1'b1; flush = 1'b1;
        tick;
        bus.in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_accept div_valid", 64'(bus.div_valid), 64'd0);
        tick;
        chk("flush_accept no_issue", 64'(bus.div_valid), 64'd0);

        // flush ten cycles into WAIT
        lat = 25;
        bus.in_op = 3'b001; bus.in_rs1 = 64'd50; bus.in_rs2 = 64'd3; bus.in_rd = 5'd11;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        tick;
        chk("wait div_o_ready", 64'(bus.div_o_ready), 64'd1);
        repeat (10) tick;
        flush = 1'b1;
        #1;
        chk("wait div_flush", 64'(bus.div_flush), 64'd1);
        tick;
        flush = 1'b0;
        #1;
        chk("wait flush out_valid", 64'(bus.out_valid), 64'd0);
        chk("wait flush in_ready", 64'(bus.in_ready), 64'd1);
        chk("wait flush div_flush_low", 64'(bus.div_flush), 64'd0);
        ov = 0;
        repeat (30) begin
            tick;
            if (bus.out_valid || bus.div_valid) ov = 1;
        end
        chk("wait flush quiet", 64'(ov), 64'd0);
        v = '{3'b001, 64'd100, 64'd7, 5'd12, 3, 0, 1'b0, 64'd14};
        run_op(v, "after_flush");

        // flush while result sits in RESP
        lat = 2;
        bus.in_op = 3'b000; bus.in_rs1 = 64'd20; bus.in_rs2 = 64'd4; bus.in_rd = 5'd13;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        ov = 0;
        for (int k = 0; k < 50 && !ov; k++) begin
            tick;
            ov = bus.out_valid;
        end
        chk("resp reached", 64'(ov), 64'd1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("resp flush out_valid", 64'(bus.out_valid), 64'd0);
        chk("resp flush in_ready", 64'(bus.in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
